// File: rtl/prog_loader.sv
// Run controller for the single-cycle processor: streams a program into instruction memory,
// holds the core in reset for a boot window, then times its run until ack or the cycle limit.
module prog_loader #(
    parameter int unsigned IW         = 9,
    parameter int unsigned AW         = 10,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned CW         = 16,
    parameter int unsigned MAX_CYCLES = 65535
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          cpu_reset,
    input  logic          cpu_ack,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [AW:0]   prog_len,
    output logic [CW-1:0] cycle_count
);

    localparam int unsigned   BW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [BW-1:0] BootLast  = BW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] CountLast = CW'(MAX_CYCLES - 1);
    localparam logic [AW-1:0] AddrLast  = '1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StBoot,
        StRun,
        StDone
    } state_e;

    state_e        state;
    logic [AW-1:0] addr;
    logic [BW-1:0] boot_cnt;
    logic          accept;

    assign in_ready   = (state == StLoad);
    assign accept     = in_valid & in_ready;
    assign imem_we    = accept;
    assign imem_addr  = addr;
    assign imem_wdata = in_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            cpu_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            prog_len    <= '0;
            cycle_count <= '0;
            addr        <= '0;
            boot_cnt    <= '0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state       <= StLoad;
                        addr        <= '0;
                        prog_len    <= '0;
                        cycle_count <= '0;
                        timeout     <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        cpu_reset   <= 1'b1;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        addr     <= addr + AW'(1);
                        prog_len <= prog_len + (AW + 1)'(1);
                        // Top address forces the end of the load so the address never wraps.
                        if (in_last || (addr == AddrLast)) begin
                            state    <= StBoot;
                            boot_cnt <= '0;
                        end
                    end
                end
                StBoot: begin
                    if (boot_cnt == BootLast) begin
                        state     <= StRun;
                        cpu_reset <= 1'b0;
                    end else begin
                        boot_cnt <= boot_cnt + BW'(1);
                    end
                end
                StRun: begin
                    // Ack takes priority over the cycle limit.
                    if (cpu_ack) begin
                        state   <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                    end else begin
                        cycle_count <= cycle_count + CW'(1);
                        if (cycle_count == CountLast) begin
                            state   <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected memory writes go through a scoreboard queue,
// control/status outputs are checked at fixed points of each load/boot/run sequence.
module tb_prog_loader;

    localparam int unsigned IW  = 9;
    localparam int unsigned AW  = 4;
    localparam int unsigned RC  = 4;
    localparam int unsigned CW  = 16;
    localparam int unsigned MXC = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          cpu_reset;
    logic          cpu_ack = 1'b0;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [AW:0]   prog_len;
    logic [CW-1:0] cycle_count;

    int total = 0;
    int bad = 0;

    logic [AW+IW-1:0] exp_q[$];
    logic [AW-1:0]    exp_addr = '0;

    prog_loader #(
        .IW(IW),
        .AW(AW),
        .RST_CYCLES(RC),
        .CW(CW),
        .MAX_CYCLES(MXC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset),
        .cpu_ack(cpu_ack),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .prog_len(prog_len),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [IW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + AW'(1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Idle beat with junk data and last set: neither may cause a write or end the load.
    task automatic idle_beat();
        in_valid = 1'b0;
        in_data  = 9'h1FF;
        in_last  = 1'b1;
        tick();
        in_last  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Write monitor: every write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (imem_we) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", imem_we, 1'b0);
            end else begin
                logic [AW+IW-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e[AW+IW-1:IW]);
                check("wr_data", imem_wdata, e[IW-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        ticks(2);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_prog_len", prog_len, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        reset = 1'b0;

        // Basic load, continuous valid
        pulse_start();
        check("load_in_ready", in_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        exp_addr = '0;
        send(9'h1A3, 1'b0);
        send(9'h0FF, 1'b0);
        send(9'h100, 1'b1);
        check("basic_prog_len", prog_len, 3);
        check("boot_in_ready", in_ready, 1'b0);
        for (int i = 0; i < RC; i++) begin
            check("boot_cpu_reset", cpu_reset, 1'b1);
            check("boot_busy", busy, 1'b1);
            tick();
        end
        check("run_cpu_reset", cpu_reset, 1'b0);
        check("run_busy", busy, 1'b1);
        check("run_first_count", cycle_count, 0);

        // Ack on the 11th RUN cycle, with an ignored start pulse mid-run
        for (int i = 1; i <= 10; i++) begin
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        check("run_count_pre_ack", cycle_count, 10);
        check("run_not_done", done, 1'b0);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check("ack_done", done, 1'b1);
        check("ack_count", cycle_count, 10);
        check("ack_timeout", timeout, 1'b0);
        check("ack_cpu_reset", cpu_reset, 1'b0);
        check("ack_busy", busy, 1'b0);

        // Backpressure load from DONE, then timeout run
        pulse_start();
        check("restart_done", done, 1'b0);
        check("restart_busy", busy, 1'b1);
        check("restart_prog_len", prog_len, 0);
        check("restart_cpu_reset", cpu_reset, 1'b1);
        exp_addr = '0;
        send(9'h055, 1'b0);
        idle_beat();
        idle_beat();
        send(9'h1AA, 1'b0);
        idle_beat();
        send(9'h0C3, 1'b1);
        check("gap_prog_len", prog_len, 3);
        ticks(RC);
        check("to_run_cpu_reset", cpu_reset, 1'b0);
        ticks(MXC - 1);
        check("to_not_done", done, 1'b0);
        check("to_count_pre", cycle_count, MXC - 1);
        tick();
        check("to_done", done, 1'b1);
        check("to_count", cycle_count, MXC);
        check("to_timeout", timeout, 1'b1);
        ticks(3);
        check("to_count_held", cycle_count, MXC);
        check("to_timeout_held", timeout, 1'b1);

        // Ack coinciding with the limit: ack wins
        pulse_start();
        check("restart_timeout_clr", timeout, 1'b0);
        exp_addr = '0;
        send(9'h1FF, 1'b1);
        check("one_prog_len", prog_len, 1);
        ticks(RC);
        ticks(MXC - 1);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        check("coinc_done", done, 1'b1);
        check("coinc_count", cycle_count, MXC - 1);
        check("coinc_timeout", timeout, 1'b0);

        // Overflow: 2**AW words without last forces BOOT
        pulse_start();
        exp_addr = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            send(9'(i * 37 + 5), 1'b0);
        end
        check("ovf_in_ready", in_ready, 1'b0);
        check("ovf_prog_len", prog_len, 1 << AW);
        check("ovf_cpu_reset", cpu_reset, 1'b1);
        in_valid = 1'b1;
        in_data  = 9'h123;
        #1;
        check("ovf_17th_we", imem_we, 1'b0);
        tick();
        in_valid = 1'b0;
        ticks(RC - 1);
        check("ovf_run_cpu_reset", cpu_reset, 1'b0);
        ticks(5);
        check("mid_run_count", cycle_count, 5);

        // Reset mid-RUN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_cpu_reset", cpu_reset, 1'b1);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_count", cycle_count, 0);
        check("mrst_in_ready", in_ready, 1'b0);
        ticks(2);
        check("mrst_idle_stays", busy, 1'b0);

        // Reload starts again at address 0
        pulse_start();
        check("reload_in_ready", in_ready, 1'b1);
        exp_addr = '0;
        send(9'h0AB, 1'b1);
        check("reload_prog_len", prog_len, 1);
        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
